// File: rtl/cwseq_pkg.sv
// Shared definitions for the control word sequencer.
// Contents:
//   cwseq_state_e          FSM state encoding (LOAD=0, PLAY=1, DONE=2)
//   CwWidthDefault         default control word width
//   DebounceCyclesDefault  default debounce length (10 ms at 50 MHz)
//   DebounceSim            short debounce length for simulation
package cwseq_pkg;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StPlay = 2'd1,
    StDone = 2'd2
  } cwseq_state_e;

  localparam int unsigned CwWidthDefault        = 33;
  localparam int unsigned DebounceCyclesDefault = 500000;
  localparam int unsigned DebounceSim           = 4;

endpackage

// File: rtl/button_debounce.sv
// Debouncer for one raw push button.
// The debounced level flips only after raw has differed from it for DEBOUNCE_CYCLES
// consecutive clocks. rise is a one-clock event, registered one clock after the level
// goes high, so a raw edge yields rise DEBOUNCE_CYCLES + 1 clocks later.
// Ports:
//   clock  system clock
//   reset  synchronous, active-low
//   raw    raw button, active-high
//   level  debounced level
//   rise   one-clock event on a debounced rising edge
module button_debounce
  import cwseq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  // Counter only needs to reach DEBOUNCE_CYCLES - 1.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            level_q, level_d;
  logic            prev_q;
  logic            rise_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (raw != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = raw;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      prev_q  <= level_q;
      rise_q  <= level_q & ~prev_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/control_word_sequencer.sv
// Records up to DEPTH control words from the switches (LOAD) and replays them one per
// debounced step press (PLAY), driving a registered control word and a one-clock step
// strobe. With nothing stored, PLAY passes the live switches through.
// Optional feature macro: CWSEQ_LOOP_EN -- when defined, playback wraps to entry 0 after
// the last entry; otherwise the FSM parks in DONE on the last entry.
// Ports:
//   clock         system clock
//   reset         synchronous, active-low
//   sw_cw         live control word from switches
//   btn_store     raw store button, active-high
//   btn_step      raw step button, active-high
//   mode_run      0 = LOAD, 1 = PLAY (asynchronous level, synchronised here)
//   control_word  registered control word to the datapath
//   step_pulse    one-clock datapath advance strobe
//   index         entry currently presented in PLAY
//   count         number of stored entries
//   full          count == DEPTH
//   state         FSM state code
module control_word_sequencer
  import cwseq_pkg::*;
#(
  parameter int unsigned CW_WIDTH        = CwWidthDefault,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CW_WIDTH-1:0]      sw_cw,
  input  logic                     btn_store,
  input  logic                     btn_step,
  input  logic                     mode_run,
  output logic [CW_WIDTH-1:0]      control_word,
  output logic                     step_pulse,
  output logic [$clog2(DEPTH)-1:0] index,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [1:0]               state
);

  localparam int unsigned Aw = $clog2(DEPTH);

  logic store_ev, step_ev;
  logic store_level, step_level;

  // Debounced levels are not needed here; only the edge events drive the FSM.
  logic unused_levels;
  assign unused_levels = store_level ^ step_level;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_store_db (
    .clock (clock),
    .reset (reset),
    .raw   (btn_store),
    .level (store_level),
    .rise  (store_ev)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_db (
    .clock (clock),
    .reset (reset),
    .raw   (btn_step),
    .level (step_level),
    .rise  (step_ev)
  );

  cwseq_state_e      state_q;
  logic [Aw:0]       count_q;
  logic [Aw-1:0]     index_q;
  logic [CW_WIDTH-1:0] cw_q;
  logic              pulse_q;
  logic              adv_q;   // a PLAY step was pulsed last cycle; advance now
  logic [1:0]        mode_sync_q;
  logic [CW_WIDTH-1:0] mem_q [DEPTH];

  logic          mode_s;
  logic          full_w;
  logic          last_w;
  logic          do_store;
  logic [Aw-1:0] next_idx;

  assign mode_s   = mode_sync_q[1];
  assign full_w   = (count_q == (Aw + 1)'(DEPTH));
  assign last_w   = ({1'b0, index_q} == count_q - (Aw + 1)'(1));
  assign next_idx = index_q + Aw'(1);
  assign do_store = (state_q == StLoad) && store_ev && !full_w;

  // Storage is not reset; count alone defines which entries are valid.
  always_ff @(posedge clock) begin
    if (do_store) begin
      mem_q[count_q[Aw-1:0]] <= sw_cw;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StLoad;
      count_q     <= '0;
      index_q     <= '0;
      cw_q        <= '0;
      pulse_q     <= 1'b0;
      adv_q       <= 1'b0;
      mode_sync_q <= '0;
    end else begin
      mode_sync_q <= {mode_sync_q[0], mode_run};
      // The pulse goes out with whatever word is already registered, so a store on
      // the same clock cannot disturb it.
      pulse_q     <= step_ev && (state_q != StDone);
      adv_q       <= 1'b0;
      if (do_store) begin
        count_q <= count_q + (Aw + 1)'(1);
      end
      unique case (state_q)
        StLoad: begin
          if (mode_s) begin
            state_q <= StPlay;
            index_q <= '0;
            cw_q    <= (count_q == '0) ? sw_cw : mem_q[0];
          end else begin
            cw_q <= sw_cw;
          end
        end
        StPlay: begin
          if (!mode_s) begin
            state_q <= StLoad;
            cw_q    <= sw_cw;
          end else if (count_q == '0) begin
            cw_q <= sw_cw;
          end else begin
            adv_q <= step_ev;
            // Advance one clock after the pulse so the word is stable through it.
            if (adv_q) begin
              if (last_w) begin
`ifdef CWSEQ_LOOP_EN
                index_q <= '0;
                cw_q    <= mem_q[0];
`else
                state_q <= StDone;
`endif
              end else begin
                index_q <= next_idx;
                cw_q    <= mem_q[next_idx];
              end
            end
          end
        end
        StDone: begin
          if (!mode_s) begin
            state_q <= StLoad;
            cw_q    <= sw_cw;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign control_word = cw_q;
  assign step_pulse   = pulse_q;
  assign index        = index_q;
  assign count        = count_q;
  assign full         = full_w;
  assign state        = state_q;

endmodule

// File: tb/tb_control_word_sequencer.sv
module tb_control_word_sequencer;
  import cwseq_pkg::*;

  localparam int unsigned CwW   = 33;
  localparam int unsigned Depth = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [CwW-1:0] sw_cw;
  logic           btn_store, btn_step, mode_run;
  logic [CwW-1:0] control_word;
  logic           step_pulse;
  logic [3:0]     index;
  logic [4:0]     count;
  logic           full;
  logic [1:0]     state;

  always #5 clk = ~clk;

  control_word_sequencer #(
    .CW_WIDTH        (CwW),
    .DEPTH           (Depth),
    .DEBOUNCE_CYCLES (DebounceSim)
  ) dut (
    .clock        (clk),
    .reset        (rst_n),
    .sw_cw        (sw_cw),
    .btn_store    (btn_store),
    .btn_step     (btn_step),
    .mode_run     (mode_run),
    .control_word (control_word),
    .step_pulse   (step_pulse),
    .index        (index),
    .count        (count),
    .full         (full),
    .state        (state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitor: counts pulses, records the word during the pulse and one clock before.
  int             n_pulses = 0;
  logic [CwW-1:0] last_pulse_cw = '0;
  logic [CwW-1:0] pulse_prev_cw = '0;
  logic [CwW-1:0] prev_cw = '0;

  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      n_pulses++;
      last_pulse_cw = control_word;
      pulse_prev_cw = prev_cw;
    end
    prev_cw = control_word;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic st, input logic sp);
    btn_store = st;
    btn_step  = sp;
    repeat (10) tick();
    btn_store = 1'b0;
    btn_step  = 1'b0;
    repeat (10) tick();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    btn_store = 1'b0;
    btn_step  = 1'b0;
    mode_run  = 1'b0;
    repeat (12) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_store = 1'b0; btn_step = 1'b0; mode_run = 1'b0; sw_cw = 33'h1_2345_6789;
    repeat (3) tick();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_tests++; if (index !== 4'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", index); end
    n_tests++; if (control_word !== 33'h0) begin n_fail++; $display("FAIL reset_cw got %h want 0", control_word); end
    n_tests++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", step_pulse); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_debounce();
    int base;
    int first;
    sw_cw = 33'h0_0000_00AB;
    repeat (3) tick();
    base = n_pulses;
    for (int i = 0; i < 5; i++) begin
      btn_step = 1'b1; tick(); tick();
      btn_step = 1'b0; tick(); tick();
    end
    btn_step = 1'b1;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (step_pulse === 1'b1 && first < 0) first = k;
    end
    btn_step = 1'b0;
    repeat (10) tick();
    n_tests++; if (first != 6) begin n_fail++; $display("FAIL debounce_latency got %0d want 6", first); end
    n_tests++; if (n_pulses - base != 1) begin n_fail++; $display("FAIL debounce_count got %0d want 1", n_pulses - base); end
    n_tests++; if (last_pulse_cw !== 33'h0_0000_00AB) begin n_fail++; $display("FAIL debounce_cw got %h want 0ab", last_pulse_cw); end
  endtask

  task automatic test_load_play();
    logic [CwW-1:0] exp_cw [3];
    int base;
    exp_cw[0] = 33'h1_0000_00A1;
    exp_cw[1] = 33'h0_0000_00B2;
    exp_cw[2] = 33'h0_0000_00C3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sw_cw = exp_cw[i];
      press(1'b1, 1'b0);
    end
    n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL load_count got %0d want 3", count); end
    sw_cw    = 33'h0_0000_0007;
    mode_run = 1'b1;
    repeat (3) tick();
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL play_enter_state got %0d want 1", state); end
    n_tests++; if (control_word !== exp_cw[0]) begin n_fail++; $display("FAIL play_enter_cw got %h want %h", control_word, exp_cw[0]); end
    for (int i = 0; i < 3; i++) begin
      base = n_pulses;
      press(1'b0, 1'b1);
      n_tests++; if (n_pulses - base != 1) begin n_fail++; $display("FAIL play_pulses[%0d] got %0d want 1", i, n_pulses - base); end
      n_tests++; if (last_pulse_cw !== exp_cw[i]) begin n_fail++; $display("FAIL play_cw[%0d] got %h want %h", i, last_pulse_cw, exp_cw[i]); end
      n_tests++; if (pulse_prev_cw !== exp_cw[i]) begin n_fail++; $display("FAIL play_stable[%0d] got %h want %h", i, pulse_prev_cw, exp_cw[i]); end
    end
    base = n_pulses;
`ifdef CWSEQ_LOOP_EN
    n_tests++; if (control_word !== exp_cw[0]) begin n_fail++; $display("FAIL loop_cw got %h want %h", control_word, exp_cw[0]); end
    n_tests++; if (index !== 4'd0) begin n_fail++; $display("FAIL loop_index got %0d want 0", index); end
    press(1'b0, 1'b1);
    n_tests++; if (n_pulses - base != 1) begin n_fail++; $display("FAIL loop_pulse got %0d want 1", n_pulses - base); end
    n_tests++; if (index !== 4'd1) begin n_fail++; $display("FAIL loop_next got %0d want 1", index); end
`else
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL done_state got %0d want 2", state); end
    n_tests++; if (control_word !== exp_cw[2]) begin n_fail++; $display("FAIL done_cw got %h want %h", control_word, exp_cw[2]); end
    press(1'b0, 1'b1);
    n_tests++; if (n_pulses - base != 0) begin n_fail++; $display("FAIL done_pulse got %0d want 0", n_pulses - base); end
    n_tests++; if (control_word !== exp_cw[2]) begin n_fail++; $display("FAIL done_hold got %h want %h", control_word, exp_cw[2]); end
`endif
    mode_run = 1'b0;
    repeat (3) tick();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL back_load_state got %0d want 0", state); end
    n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL back_load_count got %0d want 3", count); end
    n_tests++; if (control_word !== 33'h0_0000_0007) begin n_fail++; $display("FAIL back_load_cw got %h want 7", control_word); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      sw_cw = 33'h100 + 33'(i);
      press(1'b1, 1'b0);
    end
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", count); end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b want 1", full); end
    sw_cw    = 33'h0;
    mode_run = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 15; i++) press(1'b0, 1'b1);
    n_tests++; if (index !== 4'd15) begin n_fail++; $display("FAIL full_index got %0d want 15", index); end
    n_tests++; if (control_word !== 33'h10F) begin n_fail++; $display("FAIL full_last_cw got %h want 10f", control_word); end
    mode_run = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_empty_play();
    int base;
    do_reset();
    sw_cw    = 33'h5;
    mode_run = 1'b1;
    repeat (4) tick();
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL empty_state got %0d want 1", state); end
    n_tests++; if (control_word !== 33'h5) begin n_fail++; $display("FAIL empty_cw got %h want 5", control_word); end
    base = n_pulses;
    press(1'b0, 1'b1);
    n_tests++; if (n_pulses - base != 1) begin n_fail++; $display("FAIL empty_pulse got %0d want 1", n_pulses - base); end
    n_tests++; if (last_pulse_cw !== 33'h5) begin n_fail++; $display("FAIL empty_pulse_cw got %h want 5", last_pulse_cw); end
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL empty_stay got %0d want 1", state); end
    mode_run = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_simultaneous();
    int base;
    do_reset();
    sw_cw = 33'h33;
    repeat (2) tick();
    base = n_pulses;
    press(1'b1, 1'b1);
    n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL simul_count got %0d want 1", count); end
    n_tests++; if (n_pulses - base != 1) begin n_fail++; $display("FAIL simul_pulse got %0d want 1", n_pulses - base); end
    n_tests++; if (last_pulse_cw !== 33'h33) begin n_fail++; $display("FAIL simul_cw got %h want 33", last_pulse_cw); end
  endtask

  task automatic test_reset_mid_play();
    int base;
    do_reset();
    sw_cw = 33'hD1; press(1'b1, 1'b0);
    sw_cw = 33'hD2; press(1'b1, 1'b0);
    sw_cw = 33'hD3; press(1'b1, 1'b0);
    mode_run = 1'b1;
    repeat (3) tick();
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    n_tests++; if (index !== 4'd2) begin n_fail++; $display("FAIL mid_index got %0d want 2", index); end
    base = n_pulses;
    // Step event becomes visible after the 5th edge; reset lands on the edge that would pulse.
    btn_step = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    n_tests++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_pulse got %b want 0", step_pulse); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
    n_tests++; if (index !== 4'd0) begin n_fail++; $display("FAIL mid_rst_index got %0d want 0", index); end
    n_tests++; if (control_word !== 33'h0) begin n_fail++; $display("FAIL mid_cw got %h want 0", control_word); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL mid_state got %0d want 0", state); end
    btn_step = 1'b0;
    mode_run = 1'b0;
    repeat (3) tick();
    n_tests++; if (n_pulses - base != 0) begin n_fail++; $display("FAIL mid_no_pulse got %0d want 0", n_pulses - base); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    sw_cw     = '0;
    btn_store = 1'b0;
    btn_step  = 1'b0;
    mode_run  = 1'b0;
    test_reset();
    test_debounce();
    test_load_play();
    test_full();
    test_empty_play();
    test_simultaneous();
    test_reset_mid_play();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
